nand_response_checker: RTL
==========================

// Module: nand_response_checker
// PURPOSE
//  Synthesizable response analyser for 2-input NAND implementations (gate-level, behavioural,
//  dataflow). It takes (a,b) plus N_OUT DUT outputs, compares each against ~(a&b) and counts
//  mismatches per output. It tracks coverage of all four input combinations and reports
//  pass, fail or timeout.
//  Sits after the stimulus driver in on-chip self-test of the multi-NAND variants.
// PARAMETERS
//  N_OUT    3     number of DUT outputs compared in parallel (>=1)
//  CNT_W    8     width of each per-output mismatch counter and of vec_cnt
//  TO_W     16    width of idle timeout counter
//  TIMEOUT  1000  max consecutive RUN cycles without in_valid before TOUT (2..2^TO_W-1)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  start      in   1              pulse: clear results, enter RUN
//  in_valid   in   1              a/b/y valid this cycle
//  a          in   1              DUT input a
//  b          in   1              DUT input b
//  y          in   N_OUT          DUT outputs, bit i = implementation i
//  busy       out  1              state==RUN
//  done       out  1              state==DONE or TOUT (level, held until start)
//  pass       out  1              done via full coverage with zero mismatches
//  timeout    out  1              state==TOUT
//  cov        out  4              bit {a,b} set once that combination sampled
//  vec_cnt    out  CNT_W          valid samples accepted in RUN, saturating
//  err_cnt    out  N_OUT*CNT_W    per-output mismatch count, slice i = output i, saturating
//  ff_valid   out  1              first-fail capture holds data
//  ff_vec     out  2+N_OUT        {a,b,y} of first mismatching sample
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output and internal counter 0.
//  - States: IDLE, RUN, DONE, TOUT.
//    Transitions: any --start--> RUN; RUN --cov complete--> DONE; RUN --idle timer--> TOUT.
//    DONE/TOUT hold until start.
//  - start, any state: next cycle RUN with cov, vec_cnt, err_cnt, ff_*, idle timer all 0.
//    start beats in_valid in the same cycle: that sample is discarded.
//  - RUN sample (in_valid=1): exp=~(a&b); mism[i]=y[i]^exp.
//    err_cnt[i]+=mism[i], vec_cnt+=1, both saturate at 2^CNT_W-1 (no wrap).
//    cov[{a,b}]<=1.
//  - First sample with |mism: ff_vec<={a,b,y}, ff_valid<=1. Later mismatches do not overwrite.
//  - Completion: if cov|onehot({a,b})==4'hF on a valid sample -> DONE next edge (1-cycle latency).
//    pass<=1 iff all err_cnt==0 including that sample; done<=1, busy<=0.
//  - Idle timer: counts RUN cycles with in_valid=0; cleared on each valid sample.
//    Reaching TIMEOUT-1 with no valid -> TOUT next edge: done=1, timeout=1, pass=0.
//    If valid and timer expiry coincide, the valid sample wins: timer clears, no TOUT.
//  - in_valid outside RUN: ignored; no counter or cov change.
//  - Repeated combinations: vec_cnt and err_cnt still increment; cov unchanged.
//  - rst_n low mid-RUN: immediate IDLE, all results lost; start required again.
//  - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - nand_chk_pkg (shared): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2,
//    ST_TOUT=2'd3; COV_ALL=4'hF; function nand_exp(a,b).
//  - Sub-module sat_counter #(W): clr, inc -> q, saturating.
//    Instantiated N_OUT times (err_cnt) and once (vec_cnt) via generate.
//  - Top holds FSM, idle timer, cov register, first-fail capture.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all outputs 0, busy=0 within same cycle (async).
//  2 Clean sweep: start, then valid (0,0,y=111),(0,1,111),(1,0,111),(1,1,000)
//    -> done=1, pass=1 one cycle after 4th sample; vec_cnt=4, err_cnt all 0, cov=F.
//  3 Fault on output 1: same sweep but (1,1) gives y=010 -> pass=0, err_cnt[1]=1,
//    others 0, ff_vec=5'b11010, ff_valid=1.
//  4 Timeout, TIMEOUT=8: start, two valid samples, then idle -> TOUT after 8 idle cycles,
//    timeout=1, pass=0, cov=2 bits set.
//  5 Saturation, CNT_W=2: six samples of (0,0) with y[0]=0, then the remaining combos
//    -> err_cnt[0]=3, vec_cnt=3, pass=0.
//  6 Priority: start and in_valid in same cycle -> sample dropped (vec_cnt=0);
//    valid on timer-expiry cycle -> no TOUT.

Source files
------------

// File: rtl/nand_chk_pkg.sv
// nand_chk_pkg: shared state encodings, coverage constant and NAND reference for the response checker
package nand_chk_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_e;
  localparam logic [3:0] COV_ALL = 4'hF;
  function automatic logic nand_exp(input logic a, input logic b);
    return ~(a & b);
  endfunction
endpackage

// File: rtl/nand_response_checker_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its all-ones maximum
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : (inc && q_q != {W{1'b1}}) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/nand_response_checker.sv
// nand_response_checker: compares N_OUT NAND implementations against ~(a&b), tracking
// input coverage, per-output mismatch counts, first failure and an idle timeout.
module nand_response_checker
  import nand_chk_pkg::*;
#(
  parameter int N_OUT   = 3,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic                   a,
  input  logic                   b,
  input  logic [N_OUT-1:0]       y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [3:0]             cov,
  output logic [CNT_W-1:0]       vec_cnt,
  output logic [N_OUT*CNT_W-1:0] err_cnt,
  output logic                   ff_valid,
  output logic [N_OUT+1:0]       ff_vec
);
  state_e           state_q, state_d;
  logic [3:0]       cov_q, cov_d, hit;
  logic [TO_W-1:0]  tmr_q, tmr_d;
  logic             pass_q, pass_d, ffv_q, ffv_d;
  logic [N_OUT+1:0] ffvec_q, ffvec_d;
  logic [N_OUT-1:0] mism;
  logic             run, acc, full, expire;

  // start wins over a coincident sample, so acceptance excludes it
  assign run    = state_q == ST_RUN;
  assign acc    = run & in_valid & ~start;
  assign mism   = y ^ {N_OUT{nand_exp(a, b)}};
  assign hit    = 4'b0001 << {a, b};
  assign full   = (cov_q | hit) == COV_ALL;
  assign expire = run & ~in_valid & (tmr_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = start ? ST_RUN : (acc && full) ? ST_DONE : expire ? ST_TOUT : state_q;
    cov_d   = start ? '0 : acc ? (cov_q | hit) : cov_q;
    tmr_d   = (start || acc) ? '0 : run ? tmr_q + 1'b1 : tmr_q;
    pass_d  = start ? 1'b0 : (acc && full) ? (~|mism && ~|err_cnt) : pass_q;
    ffv_d   = start ? 1'b0 : (acc && |mism) ? 1'b1 : ffv_q;
    ffvec_d = start ? '0 : (acc && |mism && !ffv_q) ? {a, b, y} : ffvec_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cov_q   <= '0;
      tmr_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      tmr_q   <= tmr_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end

  for (genvar i = 0; i < N_OUT; i++) begin : g_err
    sat_counter #(.W(CNT_W)) u_err (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (start),
      .inc  (acc & mism[i]),
      .q    (err_cnt[i*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_vec (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .inc  (acc),
    .q    (vec_cnt)
  );

  assign busy     = run;
  assign done     = state_q == ST_DONE || state_q == ST_TOUT;
  assign timeout  = state_q == ST_TOUT;
  assign pass     = pass_q;
  assign cov      = cov_q;
  assign ff_valid = ffv_q;
  assign ff_vec   = ffvec_q;
endmodule
